uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 11 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_tx.sv | 85 ++++++++
 rtl/uart_rx.sv | 112 +++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the uart_rx serial input and received-byte outputs.
interface uart_rx_if;
    logic       rx_i;
    logic [7:0] d_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    modport master (output rx_i, input d_o, valid_o, frame_err_o, busy_o);
    modport slave  (input rx_i, output d_o, valid_o, frame_err_o, busy_o);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single bit; both flops reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter; accepts a new byte in the last stop-bit cycle so frames run gap-free.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);
    localparam int unsigned   TW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT);

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_tx;
    logic          w_tick;
    logic          w_last;

    assign w_tick  = (r_timer <= TW'(1));
    assign w_last  = (r_state == ST_STOP) && w_tick;
    assign o_ready = (r_state == ST_IDLE) || w_last;
    assign o_tx    = r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else if (o_ready && i_valid) begin
            r_state <= ST_START;
            r_timer <= FULL;
            r_bit   <= '0;
            r_data  <= i_data;
            r_tx    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_tx <= 1'b1;
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_timer <= FULL;
                        r_tx    <= r_data[0];
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_timer <= FULL;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit  <= r_bit + 3'd1;
                            r_tx   <= r_data[1];
                            r_data <= {1'b0, r_data[7:1]};
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver sampling mid-bit; define UART_RX_SYNC_EN to add a 2-flop input
// synchronizer (2 extra cycles on every sample and on the output).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] d_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    localparam int unsigned   TW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT);

    logic          w_rx_s;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_armed;
    logic          w_tick;

`ifdef UART_RX_SYNC_EN
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_i),
        .o_q   (w_rx_s)
    );
`else
    assign w_rx_s = rx_i;
`endif

    // Timer holds the cycles left in the current interval, so the sample lands as it reaches 0.
    assign w_tick = (r_timer <= TW'(1));
    assign busy_o = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            d_o         <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start needs a high line seen first, so a line held low through reset is ignored.
                    if (!w_rx_s && r_armed) begin
                        r_state <= ST_START;
                        r_timer <= HALF;
                        r_bit   <= '0;
                    end else if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                        r_timer <= w_rx_s ? '0 : FULL;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift[r_bit] <= w_rx_s;
                        r_timer        <= FULL;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (w_rx_s) begin
                            d_o     <= r_shift;
                            valid_o <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            r_state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
